hsm_step_sequencer: RTL and testbench

//  Parametrised N-step handshake sequencer, successor to the fixed 4-state HSM controller.

---
 rtl/hsm_step_sequencer_if.sv | 32 +++
 rtl/hsm_step_sequencer.sv | 133 +++++++++++++
 tb/tb_hsm_step_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hsm_step_sequencer_if.sv
// Purpose : bundles the sequencer's control inputs and status outputs into one port.
// Latency : none; pure signal grouping.
// Backpressure: none; host acknowledges status through ifc_read.
// Ports   : start/cond/timeout_cycles/ifc_read flow into the sequencer (slave side);
//           out/step_idx/busy/done/err/err_step flow back to the host (master side).
interface hsm_step_sequencer_if #(
    parameter int NSTEPS = 4,
    parameter int TO_W   = 16
);
    localparam int STEP_W = $clog2(NSTEPS);

    logic              start;
    logic [NSTEPS-1:0] cond;
    logic [TO_W-1:0]   timeout_cycles;
    logic              ifc_read;
    logic [NSTEPS-1:0] out;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [STEP_W-1:0] err_step;

    modport master (
        output start, cond, timeout_cycles, ifc_read,
        input  out, step_idx, busy, done, err, err_step
    );

    modport slave (
        input  start, cond, timeout_cycles, ifc_read,
        output out, step_idx, busy, done, err, err_step
    );
endinterface

// File: rtl/hsm_step_sequencer.sv
// Purpose : N-step handshake sequencer; each step waits on its own cond bit, with a
//           per-step timeout leading to ERR and a DONE/ERR status acknowledged by ifc_read.
// Latency : one cycle per step minimum; all outputs registered (reflect state after the edge).
// Backpressure: none; DONE/ERR hold until ifc_read, start is ignored outside IDLE.
// Ports   : clk, reset (sync, active-high), bus (slave modport of hsm_step_sequencer_if).
module hsm_step_sequencer #(
    parameter int NSTEPS     = 4,
    parameter int TO_W       = 16,
    parameter int AUTO_START = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    hsm_step_sequencer_if.slave  bus
);
    localparam int STEP_W = $clog2(NSTEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [TO_W-1:0]   TMR_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]   TMR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TO_W-1:0]     tmr_q, tmr_d;
    logic [STEP_W-1:0]   err_step_q, err_step_d;

    logic [NSTEPS-1:0]   out_q, out_d;
    logic [STEP_W-1:0]   step_idx_q, step_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                timed_out;

    // Equality compare only: lowering the limit below the running count never
    // fires until the counter happens to match again (it saturates, so it may never).
    assign timed_out = (bus.timeout_cycles != '0) &&
                       (tmr_q == (bus.timeout_cycles - TMR_ONE));

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tmr_d      = tmr_q;
        err_step_d = err_step_q;

        case (state_q)
            S_IDLE: begin
                if ((AUTO_START != 0) || bus.start) begin
                    state_d    = S_STEP;
                    step_d     = '0;
                    tmr_d      = '0;
                    err_step_d = '0;
                end
            end
            S_STEP: begin
                // cond takes priority over a coincident timeout.
                if (bus.cond[step_q]) begin
                    tmr_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_ONE;
                    end
                end else if (timed_out) begin
                    state_d    = S_ERR;
                    err_step_d = step_q;
                    step_d     = '0;
                    tmr_d      = '0;
                end else if (tmr_q != TMR_MAX) begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            S_DONE, S_ERR: begin
                if (bus.ifc_read) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // alongside it and stay aligned with the state they describe.
        out_d      = '0;
        step_idx_d = '0;
        if (state_d == S_STEP) begin
            out_d[step_d] = 1'b1;
            step_idx_d    = step_d;
        end
        busy_d = (state_d == S_STEP);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            tmr_q      <= '0;
            err_step_q <= '0;
            out_q      <= '0;
            step_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tmr_q      <= tmr_d;
            err_step_q <= err_step_d;
            out_q      <= out_d;
            step_idx_q <= step_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.step_idx = step_idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_step = err_step_q;
endmodule

// File: tb/tb_hsm_step_sequencer.sv
// Purpose : self-checking bench for hsm_step_sequencer (manual-start 16-bit timer
//           instance and an auto-start 8-bit timer instance).
// Latency : expectations describe outputs one edge after the inputs are driven.
// Backpressure: none.
module tb_hsm_step_sequencer;
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_STEP = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct {
        string      name;
        bit         u2;      // 0: manual-start instance, 1: auto-start instance
        bit         rst;
        bit         st;
        logic [3:0] cnd;
        logic [15:0] to;
        bit         rd;
        logic [1:0] kind;    // expected state class after the edge
        logic [1:0] k;       // expected active step (STEP only)
        logic [1:0] es;      // expected err_step
    } vec_t;

    logic clk;
    logic rst1;
    logic rst2;
    int   checks;
    int   errors;

    vec_t vecs[$];
    vec_t exp_q[$];

    hsm_step_sequencer_if #(.NSTEPS(4), .TO_W(16)) bus1 ();
    hsm_step_sequencer_if #(.NSTEPS(4), .TO_W(8))  bus2 ();

    hsm_step_sequencer #(.NSTEPS(4), .TO_W(16), .AUTO_START(0)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    hsm_step_sequencer #(.NSTEPS(4), .TO_W(8), .AUTO_START(1)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t V(string name, bit u2, bit rst, bit st, logic [3:0] cnd,
                               logic [15:0] to, bit rd, logic [1:0] kind,
                               logic [1:0] k, logic [1:0] es);
        vec_t v;
        v.name = name; v.u2 = u2; v.rst = rst; v.st = st; v.cnd = cnd;
        v.to = to; v.rd = rd; v.kind = kind; v.k = k; v.es = es;
        return v;
    endfunction

    // Expected packed view: {out, step_idx, busy, done, err, err_step}
    function automatic logic [10:0] expected_bits(vec_t v);
        logic [3:0] o;
        logic [1:0] idx;
        o   = 4'b0000;
        idx = 2'd0;
        if (v.kind == K_STEP) begin
            o[v.k] = 1'b1;
            idx    = v.k;
        end
        return {o, idx, (v.kind == K_STEP), (v.kind == K_DONE), (v.kind == K_ERR), v.es};
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t        e;
        logic [10:0] got;
        logic [10:0] want;
        @(negedge clk);
        if (v.u2) begin
            rst2 = v.rst; bus2.start = v.st; bus2.cond = v.cnd;
            bus2.timeout_cycles = v.to[7:0]; bus2.ifc_read = v.rd;
        end else begin
            rst1 = v.rst; bus1.start = v.st; bus1.cond = v.cnd;
            bus1.timeout_cycles = v.to; bus1.ifc_read = v.rd;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.u2)
            got = {bus2.out, bus2.step_idx, bus2.busy, bus2.done, bus2.err, bus2.err_step};
        else
            got = {bus1.out, bus1.step_idx, bus1.busy, bus1.done, bus1.err, bus1.err_step};
        want = expected_bits(e);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got out/idx/busy/done/err/estep=%b_%b_%b%b%b_%b want %b_%b_%b%b%b_%b",
                     e.name, got[10:7], got[6:5], got[4], got[3], got[2], got[1:0],
                     want[10:7], want[6:5], want[4], want[3], want[2], want[1:0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst1 = 1'b1; rst2 = 1'b1;
        bus1.start = 1'b0; bus1.cond = '0; bus1.timeout_cycles = '0; bus1.ifc_read = 1'b0;
        bus2.start = 1'b0; bus2.cond = '0; bus2.timeout_cycles = '0; bus2.ifc_read = 1'b0;

        // ---- manual-start instance ----
        vecs.push_back(V("reset",          0, 1, 0, 4'h0, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("reset_wins",     0, 1, 1, 4'hF, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("idle_no_start",  0, 0, 0, 4'hF, 0, 0, K_IDLE, 0, 0));
        // full pass with all cond high
        vecs.push_back(V("pass_s0",        0, 0, 1, 4'hF, 0, 0, K_STEP, 0, 0));
        vecs.push_back(V("pass_s1",        0, 0, 0, 4'hF, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("pass_s2",        0, 0, 0, 4'hF, 0, 0, K_STEP, 2, 0));
        vecs.push_back(V("pass_s3",        0, 0, 0, 4'hF, 0, 0, K_STEP, 3, 0));
        vecs.push_back(V("pass_done",      0, 0, 0, 4'hF, 0, 0, K_DONE, 0, 0));
        vecs.push_back(V("done_hold",      0, 0, 1, 4'hF, 0, 0, K_DONE, 0, 0));
        vecs.push_back(V("done_ack",       0, 0, 0, 4'hF, 0, 1, K_IDLE, 0, 0));
        vecs.push_back(V("idle_rd_ign",    0, 0, 0, 4'h0, 0, 1, K_IDLE, 0, 0));
        // timeout of 10 at step 0
        vecs.push_back(V("to10_entry",     0, 0, 1, 4'h0, 10, 0, K_STEP, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(V("to10_wait",  0, 0, 0, 4'h0, 10, 0, K_STEP, 0, 0));
        vecs.push_back(V("to10_err",       0, 0, 0, 4'h0, 10, 0, K_ERR,  0, 0));
        vecs.push_back(V("err_hold",       0, 0, 1, 4'h0, 10, 0, K_ERR,  0, 0));
        vecs.push_back(V("err_ack",        0, 0, 0, 4'h0, 10, 1, K_IDLE, 0, 0));
        // cond coincident with timeout at step 2, then timeout at step 3
        vecs.push_back(V("race_s0",        0, 0, 1, 4'h0, 3, 0, K_STEP, 0, 0));
        vecs.push_back(V("race_s1",        0, 0, 0, 4'h1, 3, 0, K_STEP, 1, 0));
        vecs.push_back(V("race_s2",        0, 0, 0, 4'h2, 3, 0, K_STEP, 2, 0));
        vecs.push_back(V("race_other_b1",  0, 0, 0, 4'hB, 3, 0, K_STEP, 2, 0));
        vecs.push_back(V("race_other_b2",  0, 0, 0, 4'hB, 3, 0, K_STEP, 2, 0));
        vecs.push_back(V("race_cond_wins", 0, 0, 0, 4'h4, 3, 0, K_STEP, 3, 0));
        vecs.push_back(V("s3_wait1",       0, 0, 0, 4'h7, 3, 0, K_STEP, 3, 0));
        vecs.push_back(V("s3_wait2",       0, 0, 0, 4'h7, 3, 0, K_STEP, 3, 0));
        vecs.push_back(V("s3_err",         0, 0, 0, 4'h7, 3, 0, K_ERR,  0, 3));
        vecs.push_back(V("s3_err_hold",    0, 0, 1, 4'h7, 3, 0, K_ERR,  0, 3));
        vecs.push_back(V("s3_err_ack",     0, 0, 0, 4'h7, 3, 1, K_IDLE, 0, 3));
        vecs.push_back(V("estep_held",     0, 0, 0, 4'h0, 3, 0, K_IDLE, 0, 3));
        // start clears err_step; ERR at step 1 then cleared by reset
        vecs.push_back(V("e1_s0",          0, 0, 1, 4'h1, 2, 0, K_STEP, 0, 0));
        vecs.push_back(V("e1_s1",          0, 0, 0, 4'h1, 2, 0, K_STEP, 1, 0));
        vecs.push_back(V("e1_wait",        0, 0, 0, 4'h0, 2, 0, K_STEP, 1, 0));
        vecs.push_back(V("e1_err",         0, 0, 0, 4'h0, 2, 0, K_ERR,  0, 1));
        vecs.push_back(V("err_reset",      0, 1, 0, 4'h0, 2, 0, K_IDLE, 0, 0));
        // timeout_cycles = 1: error after a single cycle in the step
        vecs.push_back(V("to1_entry",      0, 0, 1, 4'h0, 1, 0, K_STEP, 0, 0));
        vecs.push_back(V("to1_err",        0, 0, 0, 4'h0, 1, 0, K_ERR,  0, 0));
        vecs.push_back(V("to1_ack",        0, 0, 0, 4'h0, 1, 1, K_IDLE, 0, 0));
        // lowering the limit below the running count must not fire
        vecs.push_back(V("lower_entry",    0, 0, 1, 4'h0, 0, 0, K_STEP, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(V("lower_run",  0, 0, 0, 4'h0, 0, 0, K_STEP, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(V("lower_noerr", 0, 0, 0, 4'h0, 3, 0, K_STEP, 0, 0));
        // reset during step 1, then a normal pass
        vecs.push_back(V("midrst_prep",    0, 1, 0, 4'h0, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("midrst_s0",      0, 0, 1, 4'h1, 0, 0, K_STEP, 0, 0));
        vecs.push_back(V("midrst_s1",      0, 0, 0, 4'h1, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("midrst_s1_hold", 0, 0, 0, 4'h0, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("midrst_rst",     0, 1, 0, 4'h0, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("midrst_quiet",   0, 0, 0, 4'hF, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("after_s0",       0, 0, 1, 4'hF, 0, 0, K_STEP, 0, 0));
        vecs.push_back(V("after_s1",       0, 0, 0, 4'hF, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("after_s2",       0, 0, 0, 4'hF, 0, 0, K_STEP, 2, 0));
        vecs.push_back(V("after_s3",       0, 0, 0, 4'hF, 0, 0, K_STEP, 3, 0));
        vecs.push_back(V("after_done",     0, 0, 0, 4'hF, 0, 0, K_DONE, 0, 0));
        vecs.push_back(V("after_ack",      0, 0, 0, 4'hF, 0, 1, K_IDLE, 0, 0));

        // ---- auto-start instance (8-bit timer) ----
        vecs.push_back(V("auto_reset",     1, 1, 0, 4'hF, 0, 0, K_IDLE, 0, 0));
        vecs.push_back(V("auto_s0",        1, 0, 0, 4'hF, 0, 0, K_STEP, 0, 0));
        vecs.push_back(V("auto_s1",        1, 0, 0, 4'hF, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("auto_s2",        1, 0, 0, 4'hF, 0, 0, K_STEP, 2, 0));
        vecs.push_back(V("auto_s3",        1, 0, 0, 4'hF, 0, 0, K_STEP, 3, 0));
        vecs.push_back(V("auto_done",      1, 0, 0, 4'hF, 0, 0, K_DONE, 0, 0));
        vecs.push_back(V("auto_done_hold", 1, 0, 0, 4'hF, 0, 0, K_DONE, 0, 0));
        vecs.push_back(V("auto_ack_idle",  1, 0, 0, 4'hF, 0, 1, K_IDLE, 0, 0));
        vecs.push_back(V("auto_restart",   1, 0, 0, 4'hF, 0, 0, K_STEP, 0, 0));
        vecs.push_back(V("auto_restart1",  1, 0, 0, 4'hF, 0, 0, K_STEP, 1, 0));
        vecs.push_back(V("auto_reset2",    1, 1, 0, 4'h0, 0, 0, K_IDLE, 0, 0));
        // timer saturates: a wrapping counter would hit 199 and time out
        vecs.push_back(V("sat_entry",      1, 0, 0, 4'h0, 0, 0, K_STEP, 0, 0));
        for (int i = 0; i < 300; i++)
            vecs.push_back(V("sat_disabled", 1, 0, 0, 4'h0, 0, 0, K_STEP, 0, 0));
        for (int i = 0; i < 300; i++)
            vecs.push_back(V("sat_no_wrap", 1, 0, 0, 4'h0, 200, 0, K_STEP, 0, 0));
        vecs.push_back(V("sat_adv_s1",     1, 0, 0, 4'h1, 3, 0, K_STEP, 1, 0));
        vecs.push_back(V("sat_s1_wait1",   1, 0, 0, 4'h0, 3, 0, K_STEP, 1, 0));
        vecs.push_back(V("sat_s1_wait2",   1, 0, 0, 4'h0, 3, 0, K_STEP, 1, 0));
        vecs.push_back(V("sat_s1_err",     1, 0, 0, 4'h0, 3, 0, K_ERR,  0, 1));

        foreach (vecs[i])
            run_vec(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
